// File: rtl/batch_sample_mem.sv
// batch_sample_mem: multi-read-port synchronous memory; it zeroes itself after reset, then serves one writer and NUM_RD registered readers.
module batch_sample_mem #(
    parameter int DEPTH = 60,
    parameter int DATA_W = 48,
    parameter int NUM_RD = 3,
    parameter int WRITE_FIRST = 1,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic                     ready,
    output logic                     addr_err
);
    localparam logic [0:0] CLEAR = 1'b0, RUN = 1'b1;
    logic [0:0] state;
    logic [ADDR_W-1:0] clr_cnt;
    logic [NUM_RD-1:0] rd_bad;
    logic wr_ok, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < (ADDR_W + 1)'(DEPTH);
    endfunction
    // The clear sweep owns the write port until it finishes; user writes are dropped meanwhile.
    assign wr_ok = wr_en && in_range(wr_addr);
    assign mem_we = rst && (state == CLEAR || wr_ok);
    assign mem_addr = state == CLEAR ? clr_cnt : wr_addr;
    assign mem_din = state == CLEAR ? '0 : wr_data;
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= CLEAR;
            clr_cnt <= '0;
            ready <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            ready <= state == RUN;
            addr_err <= addr_err | (wr_en && !in_range(wr_addr)) | (|rd_bad);
            if (state == CLEAR) begin
                clr_cnt <= clr_cnt + ADDR_W'(1);
                if (clr_cnt == ADDR_W'(DEPTH - 1)) state <= RUN;
            end
        end
    end
    // One replicated bank per read port, all fed the same write.
    for (genvar k = 0; k < NUM_RD; k++) begin : g_port
        logic [DATA_W-1:0] mem [DEPTH];
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] q;
        assign a = rd_addr[k*ADDR_W +: ADDR_W];
        assign rd_bad[k] = !in_range(a);
        assign rd_data[k*DATA_W +: DATA_W] = q;
        always_ff @(posedge clk) begin
            if (mem_we) mem[mem_addr] <= mem_din;
        end
        always_ff @(posedge clk) begin
            if (!rst || state == CLEAR || rd_bad[k]) q <= '0;
            else q <= (WRITE_FIRST != 0 && wr_ok && wr_addr == a) ? wr_data : mem[a];
        end
    end
endmodule

// File: tb/tb_batch_sample_mem.sv
// tb_batch_sample_mem: directed scoreboard bench running write-first and read-first instances side by side.
module tb_batch_sample_mem;
    logic clk = 1'b0;
    logic rst;
    logic wr_en;
    logic [5:0] wr_addr;
    logic [47:0] wr_data;
    logic [17:0] rd_addr;
    logic [143:0] rd1, rd0;
    logic ready1, ready0, err1, err0;
    int n_chk = 0;
    int n_fail = 0;
    logic [47:0] model [60];
    logic err_exp = 1'b0;
    typedef struct packed {
        logic [2:0][47:0] d1;
        logic [2:0][47:0] d0;
        logic err;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    batch_sample_mem #(.DEPTH(60), .DATA_W(48), .NUM_RD(3), .WRITE_FIRST(1)) dut1 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd1), .ready(ready1), .addr_err(err1));
    batch_sample_mem #(.DEPTH(60), .DATA_W(48), .NUM_RD(3), .WRITE_FIRST(0)) dut0 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd0), .ready(ready0), .addr_err(err0));

    task automatic check(input string tag, input logic [143:0] obs, input logic [143:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic we, input int wa, input logic [47:0] wd, input int a0, input int a1, input int a2);
        int a[3];
        exp_t e;
        a = '{a0, a1, a2};
        wr_en = we;
        wr_addr = wa[5:0];
        wr_data = wd;
        rd_addr = {a2[5:0], a1[5:0], a0[5:0]};
        for (int k = 0; k < 3; k++) begin
            if (a[k] >= 60) begin
                e.d1[k] = '0;
                e.d0[k] = '0;
                err_exp = 1'b1;
            end else begin
                e.d0[k] = model[a[k]];
                e.d1[k] = (we && wa == a[k]) ? wd : model[a[k]];
            end
        end
        if (we) begin
            if (wa < 60) model[wa] = wd;
            else err_exp = 1'b1;
        end
        e.err = err_exp;
        q.push_back(e);
        @(posedge clk);
        #1;
        e = q.pop_front();
        check("rd_wf1", rd1, e.d1);
        check("rd_wf0", rd0, e.d0);
        check("addr_err", {err1, err0}, {e.err, e.err});
        wr_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int cyc;
        rst = 1'b0;
        wr_en = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        rd_addr = '0;
        for (int i = 0; i < 60; i++) model[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_rd", {rd1, rd0}, '0);
        check("reset_ready", {ready1, ready0}, '0);
        check("reset_err", {err1, err0}, '0);
        // Release reset and watch the clear sweep; a write lands mid-sweep and must be dropped.
        rst = 1'b1;
        for (int c = 1; c <= 61; c++) begin
            @(posedge clk);
            #1;
            check("clr_ready", {ready1, ready0}, (c >= 61) ? 2'b11 : 2'b00);
            check("clr_rd", {rd1, rd0}, '0);
            if (c == 9) begin
                wr_en = 1'b1;
                wr_addr = 6'd5;
                wr_data = 48'h7;
            end else wr_en = 1'b0;
        end
        for (int i = 0; i < 60; i++) step(1'b0, 0, '0, i, i, i);
        step(1'b1, 17, 48'hABCDEF012345, 0, 0, 0);
        step(1'b0, 0, '0, 17, 18, 18);
        step(1'b1, 3, 48'h9, 0, 0, 0);
        step(1'b1, 3, 48'h5, 0, 0, 3);
        step(1'b0, 0, '0, 0, 0, 3);
        step(1'b1, 17, 48'h1234, 17, 17, 17);
        step(1'b0, 0, '0, 17, 17, 17);
        // Ring traffic: batch slot b%4 is written while older slots are read back.
        for (int b = 0; b < 8; b++) begin
            for (int c = 0; c < 15; c++) begin
                int cnt;
                logic [31:0] r;
                cnt = b % 4;
                r = $urandom;
                step(1'b1, cnt * 15 + c, {b[7:0], c[7:0], r},
                     ((cnt + 2) % 4) * 15 + 14 - c, ((cnt + 1) % 4) * 15 + c, ((cnt + 2) % 4) * 15 + c);
            end
        end
        step(1'b1, 60, 48'hFFFF, 0, 0, 0);
        step(1'b0, 0, '0, 0, 63, 0);
        step(1'b0, 0, '0, 17, 3, 59);
        step(1'b0, 0, '0, 5, 45, 30);
        for (int i = 0; i < 60; i++) step(1'b1, i, 48'(i), 0, 0, 0);
        step(1'b0, 0, '0, 59, 30, 1);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_ready", {ready1, ready0}, '0);
        check("midrst_rd", {rd1, rd0}, '0);
        check("midrst_err", {err1, err0}, '0);
        rst = 1'b1;
        err_exp = 1'b0;
        for (int i = 0; i < 60; i++) model[i] = '0;
        cyc = 0;
        while (!(ready1 && ready0) && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("midrst_clr_cycles", 144'(cyc), 144'(61));
        for (int i = 0; i < 60; i++) step(1'b0, 0, '0, i, 59 - i, i);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
